// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall sequencer for a 5-stage pipeline: drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
// Optional build macro HAZ_STATS_EN adds saturating stall/flush statistics counters.
module pipe_hazard_ctrl #(
  parameter int REG_W        = 6,
  parameter int LU_STALLS    = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_rd,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             redirect,
  input  logic             mem_req,
  input  logic             mem_ack,
  output logic             pc_wrt,
  output logic             ifid_wrt,
  output logic             ifid_flush,
  output logic             idex_wrt,
  output logic             idex_flush,
  output logic             exmem_wrt,
  output logic             mem_timeout
`ifdef HAZ_STATS_EN
  ,
  output logic [15:0]      stall_cnt,
  output logic [15:0]      flush_cnt
`endif
);

  typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;
  typedef enum logic [1:0] {O_NORM, O_FRZ, O_SQ, O_BUB} oset_t;

  // cnt holds the number of stall/flush cycles already issued, so the
  // final cycle of a sequence is the one where cnt equals (length - 1).
  localparam logic [3:0] LU_LAST = 4'(LU_STALLS - 1);
  localparam logic [3:0] FL_LAST = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] TO_LAST = 4'(MEM_TIMEOUT);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  oset_t      oset;
  logic       to_set;
  logic       lu;
  logic       mem_stall;

  assign lu = ex_mem_rd && (ex_rd != '0) &&
              ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_stall = mem_req && !mem_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (to_set) mem_timeout <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    oset      = O_NORM;
    to_set    = 1'b0;
    case (state)
      RUN: begin
        if (mem_stall) begin
          oset      = O_FRZ;
          state_nxt = MEM_WAIT;
          cnt_nxt   = 4'd1;
        end else if (redirect) begin
          oset = O_SQ;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = 4'd1;
          end
        end else if (lu) begin
          oset = O_BUB;
          if (LU_STALLS > 1) begin
            state_nxt = LU_STALL;
            cnt_nxt   = 4'd1;
          end
        end
      end
      MEM_WAIT: begin
        // MEM is frozen, so redirect and load-use are not acted on here.
        if (mem_ack) begin
          oset      = O_NORM;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else if (cnt == TO_LAST) begin
          oset      = O_NORM;
          to_set    = 1'b1;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          oset    = O_FRZ;
          cnt_nxt = cnt + 4'd1;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          oset      = O_FRZ;
          state_nxt = MEM_WAIT;
          cnt_nxt   = 4'd1;
        end else if (redirect) begin
          oset    = O_SQ;
          cnt_nxt = 4'd1;
        end else if (cnt == FL_LAST) begin
          oset      = O_SQ;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          oset    = O_SQ;
          cnt_nxt = cnt + 4'd1;
        end
      end
      LU_STALL: begin
        if (mem_stall) begin
          oset      = O_FRZ;
          state_nxt = MEM_WAIT;
          cnt_nxt   = 4'd1;
        end else if (redirect) begin
          oset = O_SQ;
          if (FLUSH_CYCLES > 1) begin
            state_nxt = FLUSH;
            cnt_nxt   = 4'd1;
          end else begin
            state_nxt = RUN;
            cnt_nxt   = '0;
          end
        end else if (cnt == LU_LAST) begin
          oset      = O_BUB;
          state_nxt = RUN;
          cnt_nxt   = '0;
        end else begin
          oset    = O_BUB;
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode; reset forces every register to hold and both flushes on.
  always_comb begin
    pc_wrt     = 1'b1;
    ifid_wrt   = 1'b1;
    ifid_flush = 1'b0;
    idex_wrt   = 1'b1;
    idex_flush = 1'b0;
    exmem_wrt  = 1'b1;
    case (oset)
      O_FRZ: begin
        pc_wrt    = 1'b0;
        ifid_wrt  = 1'b0;
        idex_wrt  = 1'b0;
        exmem_wrt = 1'b0;
      end
      O_SQ: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      O_BUB: begin
        pc_wrt     = 1'b0;
        ifid_wrt   = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
    if (!rst_n) begin
      pc_wrt     = 1'b0;
      ifid_wrt   = 1'b0;
      ifid_flush = 1'b1;
      idex_wrt   = 1'b0;
      idex_flush = 1'b1;
      exmem_wrt  = 1'b0;
    end
  end

`ifdef HAZ_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic redir_acc;
  // SQ only ever coincides with a live redirect when one is being accepted.
  assign redir_acc = redirect && (oset == O_SQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (oset == O_FRZ || oset == O_BUB) stall_cnt <= sat_inc16(stall_cnt);
      if (redir_acc) flush_cnt <= sat_inc16(flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: load-use, redirect, memory wait/timeout,
// priority and reset scenarios with hand-computed control vectors.
module tb_pipe_hazard_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_rs, id_rt, ex_rd;
  logic       id_uses_rt, ex_mem_rd, redirect, mem_req, mem_ack;
  logic       pc_wrt, ifid_wrt, ifid_flush, idex_wrt, idex_flush, exmem_wrt;
  logic       mem_timeout;
`ifdef HAZ_STATS_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  // {pc_wrt, ifid_wrt, ifid_flush, idex_wrt, idex_flush, exmem_wrt}
  localparam logic [5:0] NORM = 6'b110101;
  localparam logic [5:0] FRZ  = 6'b000000;
  localparam logic [5:0] SQ   = 6'b111111;
  localparam logic [5:0] BUB  = 6'b000111;
  localparam logic [5:0] RST  = 6'b001010;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_rd(ex_mem_rd), .ex_rd(ex_rd),
    .redirect(redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_wrt(pc_wrt), .ifid_wrt(ifid_wrt), .ifid_flush(ifid_flush),
    .idex_wrt(idex_wrt), .idex_flush(idex_flush), .exmem_wrt(exmem_wrt),
    .mem_timeout(mem_timeout)
`ifdef HAZ_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  wire [5:0] outs = {pc_wrt, ifid_wrt, ifid_flush, idex_wrt, idex_flush, exmem_wrt};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Inputs are already set; check outputs mid-cycle, then move past the edge.
  task automatic step(input string tag, input logic [5:0] want);
    @(negedge clk);
    chk(tag, {26'd0, outs}, {26'd0, want});
    @(posedge clk);
    #1;
  endtask

  task automatic clr_lu();
    ex_mem_rd = 1'b0; ex_rd = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; redirect = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    clr_lu();
    @(negedge clk);
    chk("rst_outs", {26'd0, outs}, {26'd0, RST});
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
`ifdef HAZ_STATS_EN
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    step("idle", NORM);

    // load-use via rs
    ex_mem_rd = 1'b1; ex_rd = 6'd5; id_rs = 6'd5;
    step("lu_rs0", BUB);
    clr_lu();
    step("lu_rs1", BUB);
    step("lu_rs2", NORM);

    // no hazard: ex_rd is r0
    ex_mem_rd = 1'b1; ex_rd = 6'd0; id_rs = 6'd0;
    step("lu_r0", NORM);
    // no hazard: rt matches but rt not read
    ex_rd = 6'd5; id_rs = 6'd3; id_rt = 6'd5; id_uses_rt = 1'b0;
    step("lu_rt_unused", NORM);
    // hazard via rt
    id_uses_rt = 1'b1;
    step("lu_rt0", BUB);
    clr_lu();
    step("lu_rt1", BUB);
    step("lu_rt2", NORM);

    // single redirect pulse
    redirect = 1'b1;
    step("rd0", SQ);
    redirect = 1'b0;
    step("rd1", SQ);
    step("rd2", NORM);
`ifdef HAZ_STATS_EN
    chk("stat_stall", {16'd0, stall_cnt}, 32'd4);
    chk("stat_flush", {16'd0, flush_cnt}, 32'd1);
`endif

    // second redirect during FLUSH restarts the count
    redirect = 1'b1;
    step("rr0", SQ);
    step("rr1", SQ);
    redirect = 1'b0;
    step("rr2", SQ);
    step("rr3", NORM);

    // memory wait, ack on the 4th cycle
    mem_req = 1'b1;
    step("mw0", FRZ);
    step("mw1", FRZ);
    step("mw2", FRZ);
    mem_ack = 1'b1;
    step("mw_ack", NORM);
    mem_req = 1'b0; mem_ack = 1'b0;
    step("mw_after", NORM);
    chk("mw_no_timeout", {31'd0, mem_timeout}, 32'd0);

    // memory timeout
    mem_req = 1'b1;
    for (int i = 0; i < 15; i++) step($sformatf("to_frz%0d", i), FRZ);
    chk("to_pending", {31'd0, mem_timeout}, 32'd0);
    step("to_release", NORM);
    mem_req = 1'b0;
    chk("to_set", {31'd0, mem_timeout}, 32'd1);
    step("to_after", NORM);
    chk("to_sticky", {31'd0, mem_timeout}, 32'd1);

    // priority: mem stall beats redirect and load-use
    mem_req = 1'b1; redirect = 1'b1;
    ex_mem_rd = 1'b1; ex_rd = 6'd5; id_rs = 6'd5;
    step("pri0", FRZ);
    step("pri1", FRZ);
    mem_ack = 1'b1;
    step("pri_ack", NORM);
    mem_req = 1'b0; mem_ack = 1'b0; clr_lu();
    step("pri_sq0", SQ);
    redirect = 1'b0;
    step("pri_sq1", SQ);
    step("pri_norm", NORM);

    // reset in the middle of MEM_WAIT
    mem_req = 1'b1;
    step("rw0", FRZ);
    step("rw1", FRZ);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rw_rst_outs", {26'd0, outs}, {26'd0, RST});
    chk("rw_rst_timeout", {31'd0, mem_timeout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; mem_req = 1'b0;
    step("rw_run", NORM);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
